m68k_dma_arbiter: RTL and testbench
===================================

Name: m68k_dma_arbiter

Overview:
- Shares the 68000-compatible CPU bus between the CPU and two DMA requesters, for example SCSI DMA and the video/sound fetch engine.
- Runs the BR/BG/BGACK protocol against the CPU bus wrapper and grants the bus to one requester at a time, round-robin.
- Limits each bus tenure and releases the bus cleanly back to the CPU.
- Sits between the CPU wrapper's arbitration pins and the DMA engines' request/grant handshakes.

Parameters:
- MAX_TENURE, 64: maximum phi1 pulses a requester may own the bus before a forced release is requested.
- RELEASE_GAP, 2: minimum phi1 pulses the bus stays with the CPU after a release, before the next assertion of br_n.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- phi1  in  1  CPU phase-1 clock enable, one clk wide
- phi2  in  1  CPU phase-2 clock enable, one clk wide
- bg_n  in  1  bus grant from the CPU wrapper
- as_n  in  1  CPU address strobe, used for bus-busy detection
- br_n  out  1  bus request to the CPU wrapper
- bgack_n  out  1  bus grant acknowledge to the CPU wrapper
- req  in  2  per-requester bus request, level, held until done
- busy  in  2  per-requester "bus cycle in progress"; the requester must not start a cycle unless its grant is high
- grant  out  2  one-hot ownership; at most one bit set
- yield  out  2  per-requester "finish current cycle and drop req"
- owner  out  1  index of the last/current granted requester
- dma_active  out  1  high while bgack_n is low

Behaviour:
- Reset values: br_n=1, bgack_n=1, grant=0, yield=0, owner=0, dma_active=0, state=IDLE, tenure counter=0, gap counter=0.
- Timing of outputs: br_n, bgack_n and grant change only on clk edges where phi2=1. yield and the counters update only on phi1=1. Between enables all outputs hold.
- States: IDLE -> REQ -> WAIT_BUS -> OWN -> RELEASE -> GAP -> IDLE.
- IDLE:
  - If req != 0 and gap counter == 0, on phi2 drive br_n=0 and go to REQ.
  - Pick the next owner on entry to REQ: the requester not equal to owner if both are requesting, else the single requester.
- REQ:
  - Wait for bg_n=0 sampled on phi1.
  - If the chosen req drops before bg_n=0 and the other req is low, deassert br_n on phi2 and return to IDLE.
  - If the other req is high, re-target to it and stay in REQ.
- WAIT_BUS:
  - Entered when bg_n=0.
  - On the first phi2 where as_n=1 (sampled on the preceding phi1): drive bgack_n=0, br_n=1, grant[owner]=1, dma_active=1, go to OWN.
- OWN:
  - Tenure counter increments each phi1 and saturates at MAX_TENURE.
  - Reaching MAX_TENURE with the other req high sets yield[owner]=1.
  - With the other req low, no yield is raised and the tenure is unbounded.
  - When req[owner]=0 and busy[owner]=0 on a phi2: grant=0, yield=0, go to RELEASE.
  - req[owner] dropping while busy[owner]=1 waits for busy to fall; grant stays high.
- RELEASE:
  - On the next phi2: bgack_n=1, dma_active=0, tenure counter=0, gap counter=RELEASE_GAP, go to GAP.
  - This gives one full phi2 of grant=0 before bgack_n rises.
- GAP:
  - Gap counter decrements on phi1. At 0, go to IDLE.
  - A requester must never see back-to-back tenures without a CPU window.
- Simultaneous events:
  - Both req rising on the same phi1 from reset: requester 1 wins, because owner=0 and the other is preferred; owner then becomes 1.
  - bg_n and req drop on the same edge in REQ: treated as a drop. br_n releases, and bgack_n is never asserted.
- Protocol invariants:
  - grant is nonzero only while bgack_n=0.
  - br_n=0 and bgack_n=0 never overlap for more than the single phi2 of handover. They are equal-edge transitions, so a strict implementation shows no overlap.
- Reset mid-operation returns all outputs to reset values on the next clk edge, regardless of phi1/phi2.
- bg_n returning to 1 during OWN is ignored; the BGACK holder owns the bus until release.

Test Plan:
- Single request:
  - Stimulus: req=01; the CPU model asserts bg_n=0 3 phases after br_n=0; as_n=1.
  - Required: br_n=0 on the first phi2, bgack_n=0 and grant=01 on the phi2 after bg_n is seen, br_n=1 on that same phi2.
  - Then drop req with busy=0: grant=00, and bgack_n=1 exactly one phi2 later.
- CPU mid-cycle:
  - Stimulus: bg_n=0 while as_n=0 for 4 phases.
  - Required: bgack_n stays 1 until the first phi2 after as_n=1 is sampled. No grant bit is set before that.
- Round-robin and tenure limit:
  - Stimulus: MAX_TENURE=8, req=11 held.
  - Required: grant=10 first.
  - After 8 phi1: yield=10. With busy=1 for 2 more phi1, grant holds. busy=0 and req[1]=0 then cause release.
  - After GAP of 2 phi1: grant=01.
- Request withdrawn before grant:
  - Stimulus: req=01 asserted, then dropped before bg_n falls.
  - Required: br_n returns to 1, bgack_n never goes low, state returns to IDLE.
- Reset during OWN:
  - Stimulus: assert reset for one clk during OWN.
  - Required: br_n=1, bgack_n=1, grant=00, dma_active=0 on the next clk edge.
  - After reset release with req=00: all outputs stay idle.

Source files
------------

// File: rtl/m68k_dma_arbiter.sv
// m68k_dma_arbiter: shares the 68000 CPU bus between the CPU and two DMA
// requesters using the BR/BG/BGACK handshake, round-robin between requesters,
// with a bounded tenure and a guaranteed CPU window between DMA tenures.
module m68k_dma_arbiter #(
    parameter int unsigned MAX_TENURE  = 64,
    parameter int unsigned RELEASE_GAP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       phi1,
    input  logic       phi2,
    input  logic       bg_n,
    input  logic       as_n,
    input  logic [1:0] req,
    input  logic [1:0] busy,
    output logic       br_n,
    output logic       bgack_n,
    output logic [1:0] grant,
    output logic [1:0] yield,
    output logic       owner,
    output logic       dma_active
);

    localparam int unsigned TEN_W = $clog2(MAX_TENURE + 1);
    localparam int unsigned GAP_W = (RELEASE_GAP < 2) ? 1 : $clog2(RELEASE_GAP + 1);
    localparam logic [TEN_W-1:0] TEN_MAX  = TEN_W'(MAX_TENURE);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RELEASE_GAP);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_BUS,
        ST_OWN,
        ST_RELEASE,
        ST_GAP
    } state_t;

    state_t           state_q;
    logic             br_n_q;
    logic             bgack_n_q;
    logic [1:0]       grant_q;
    logic [1:0]       yield_q;
    logic             owner_q;
    logic             dma_active_q;
    logic [TEN_W-1:0] tenure_q;
    logic [GAP_W-1:0] gap_q;
    logic             as_idle_q;

    logic             other;
    logic [1:0]       owner_sel;
    logic [TEN_W-1:0] tenure_inc;

    // Helpers: the non-owning requester, one-hot of owner, saturating tenure step
    assign other      = ~owner_q;
    assign owner_sel  = owner_q ? 2'b10 : 2'b01;
    assign tenure_inc = (tenure_q == TEN_MAX) ? tenure_q : tenure_q + TEN_W'(1);

    // Arbitration FSM; bus pins move on phi2, counters and yield on phi1
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            br_n_q       <= 1'b1;
            bgack_n_q    <= 1'b1;
            grant_q      <= 2'b00;
            yield_q      <= 2'b00;
            owner_q      <= 1'b0;
            dma_active_q <= 1'b0;
            tenure_q     <= '0;
            gap_q        <= '0;
            as_idle_q    <= 1'b0;
        end else begin
            if (phi1) begin
                as_idle_q <= as_n;
            end

            case (state_q)
                ST_IDLE: begin
                    if (phi2 && (req != 2'b00) && (gap_q == '0)) begin
                        br_n_q  <= 1'b0;
                        // Both requesting: prefer the one that did not own last
                        owner_q <= (req == 2'b11) ? ~owner_q : req[1];
                        state_q <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (phi1 && (req != 2'b00)) begin
                        if (!req[owner_q]) begin
                            owner_q <= ~owner_q;
                        end
                        if (!bg_n) begin
                            state_q <= ST_WAIT_BUS;
                        end
                    end
                    // A full withdrawal wins over a grant seen on the same edge
                    if (phi2 && (req == 2'b00)) begin
                        br_n_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end

                ST_WAIT_BUS: begin
                    // Take the bus only once the CPU has no cycle in flight
                    if (phi2 && as_idle_q) begin
                        bgack_n_q    <= 1'b0;
                        br_n_q       <= 1'b1;
                        grant_q      <= owner_sel;
                        dma_active_q <= 1'b1;
                        state_q      <= ST_OWN;
                    end
                end

                ST_OWN: begin
                    if (phi1) begin
                        tenure_q <= tenure_inc;
                        if ((tenure_inc == TEN_MAX) && req[other]) begin
                            yield_q <= owner_sel;
                        end
                    end
                    // Grant is held until the owner has both dropped req and finished its cycle
                    if (phi2 && !req[owner_q] && !busy[owner_q]) begin
                        grant_q <= 2'b00;
                        yield_q <= 2'b00;
                        state_q <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (phi2) begin
                        bgack_n_q    <= 1'b1;
                        dma_active_q <= 1'b0;
                        tenure_q     <= '0;
                        gap_q        <= GAP_LOAD;
                        state_q      <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (phi1) begin
                        if (gap_q <= GAP_W'(1)) begin
                            gap_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            gap_q <= gap_q - GAP_W'(1);
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign br_n       = br_n_q;
    assign bgack_n    = bgack_n_q;
    assign grant      = grant_q;
    assign yield      = yield_q;
    assign owner      = owner_q;
    assign dma_active = dma_active_q;

endmodule

// File: tb/tb_m68k_dma_arbiter.sv
// Bench for m68k_dma_arbiter: a phase generator and CPU grant model drive the
// DUT; each test queues the output transitions it requires (with the number of
// phi2 pulses allowed since the previous transition or stimulus) and a monitor
// pops and compares them whenever the DUT outputs change.
module tb_m68k_dma_arbiter;

    logic       clk;
    logic       reset;
    logic       phi1;
    logic       phi2;
    logic       bg_n;
    logic       as_n;
    logic [1:0] req;
    logic [1:0] busy;
    logic       br_n;
    logic       bgack_n;
    logic [1:0] grant;
    logic [1:0] yield;
    logic       owner;
    logic       dma_active;

    m68k_dma_arbiter #(
        .MAX_TENURE (8),
        .RELEASE_GAP(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .phi1      (phi1),
        .phi2      (phi2),
        .bg_n      (bg_n),
        .as_n      (as_n),
        .req       (req),
        .busy      (busy),
        .br_n      (br_n),
        .bgack_n   (bgack_n),
        .grant     (grant),
        .yield     (yield),
        .owner     (owner),
        .dma_active(dma_active)
    );

    // Snapshot layout: {br_n, bgack_n, grant[1:0], yield[1:0], owner, dma_active}
    localparam logic [7:0] S_IDLE0  = 8'hC0;
    localparam logic [7:0] S_IDLE1  = 8'hC2;
    localparam logic [7:0] S_BR0    = 8'h40;
    localparam logic [7:0] S_BR1    = 8'h42;
    localparam logic [7:0] S_OWN0   = 8'h91;
    localparam logic [7:0] S_OWN1   = 8'hA3;
    localparam logic [7:0] S_YLD1   = 8'hAB;
    localparam logic [7:0] S_REL0   = 8'h81;
    localparam logic [7:0] S_REL1   = 8'h83;

    typedef struct packed {
        logic [7:0]         snap;
        logic signed [31:0] dly;
    } exp_t;

    exp_t       exp_q[$];
    int         checks;
    int         failures;
    string      cur_test;
    int         cpu_delay;
    int         cpu_cnt;
    int         ph;
    int         p2cnt;
    int         last_p2;
    int         mark_p2;
    int         ev_idx;
    bit         mon_en;
    logic [7:0] prev_snap;
    logic [7:0] last_exp;
    logic [7:0] mon_snap;
    exp_t       mon_e;
    int         mon_ref;

    function automatic logic [7:0] cur_snap();
        return {br_n, bgack_n, grant, yield, owner, dma_active};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input logic [7:0] s, input int d);
        exp_t e;
        e.snap = s;
        e.dly  = d;
        exp_q.push_back(e);
    endtask

    task automatic mark();
        mark_p2 = p2cnt;
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Phase enables and CPU model: BG follows BR after cpu_delay phase pulses
    initial begin
        ph      = 3;
        phi1    = 1'b0;
        phi2    = 1'b0;
        bg_n    = 1'b1;
        cpu_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            ph   = (ph + 1) % 4;
            phi1 = (ph == 0);
            phi2 = (ph == 2);
            if (br_n === 1'b0) begin
                if (phi1 || phi2) cpu_cnt++;
                if (cpu_cnt >= cpu_delay) bg_n = 1'b0;
            end else begin
                cpu_cnt = 0;
                bg_n    = 1'b1;
            end
        end
    end

    // Monitor: every output change must match the next queued transition
    always @(posedge clk) begin
        #1;
        if (phi2) p2cnt++;
        if (mon_en) begin
            mon_snap = cur_snap();
            if (mon_snap !== prev_snap) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("%s_unexpected", cur_test), 32'(mon_snap), 32'(last_exp));
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_ref = (mark_p2 > last_p2) ? mark_p2 : last_p2;
                    ev_idx++;
                    chk($sformatf("%s_ev%0d", cur_test, ev_idx), 32'(mon_snap), 32'(mon_e.snap));
                    if (mon_e.dly >= 0)
                        chk($sformatf("%s_ev%0d_phi2", cur_test, ev_idx),
                            32'(p2cnt - mon_ref), 32'(mon_e.dly));
                    last_exp = mon_e.snap;
                end
                if (grant != 2'b00)
                    chk($sformatf("%s_grant_wo_bgack", cur_test), 32'(bgack_n), 32'd0);
                if (br_n == 1'b0)
                    chk($sformatf("%s_br_bgack_overlap", cur_test), 32'(bgack_n), 32'd1);
                prev_snap = mon_snap;
                last_p2   = p2cnt;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        p2cnt     = 0;
        last_p2   = 0;
        mark_p2   = 0;
        ev_idx    = 0;
        mon_en    = 1'b0;
        cpu_delay = 3;
        cur_test  = "reset";
        reset     = 1'b1;
        req       = 2'b00;
        busy      = 2'b00;
        as_n      = 1'b1;
        prev_snap = S_IDLE0;
        last_exp  = S_IDLE0;

        repeat (4) @(negedge clk);
        chk("reset_state", 32'(cur_snap()), 32'(S_IDLE0));
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (8) @(negedge clk);

        // Single request, CPU idle
        cur_test = "single";
        expect_ev(S_BR0, 1);
        expect_ev(S_OWN0, 2);
        req = 2'b01;
        mark();
        wait_drain("single_grant", 100);
        repeat (5) @(negedge clk);
        expect_ev(S_REL0, 1);
        expect_ev(S_IDLE0, 1);
        req = 2'b00;
        mark();
        wait_drain("single_release", 100);
        repeat (16) @(negedge clk);

        // CPU still mid-cycle when BG arrives
        cur_test = "midcycle";
        as_n = 1'b0;
        expect_ev(S_BR0, 1);
        expect_ev(S_OWN0, 1);
        req = 2'b01;
        mark();
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bg_n !== 1'b0 && n < 100);
            chk("midcycle_bg_seen", 32'(bg_n), 32'd0);
        end
        repeat (8) @(negedge clk);
        chk("midcycle_no_early_grant", 32'(cur_snap()), 32'(S_BR0));
        as_n = 1'b1;
        mark();
        wait_drain("midcycle_grant", 100);
        repeat (3) @(negedge clk);
        expect_ev(S_REL0, 1);
        expect_ev(S_IDLE0, 1);
        req = 2'b00;
        mark();
        wait_drain("midcycle_release", 100);
        repeat (16) @(negedge clk);

        // Round robin with tenure limit
        cur_test = "rr";
        expect_ev(S_BR1, 1);
        expect_ev(S_OWN1, 2);
        expect_ev(S_YLD1, 7);
        req = 2'b11;
        mark();
        wait_drain("rr_yield", 200);
        expect_ev(S_REL1, 1);
        expect_ev(S_IDLE1, 1);
        expect_ev(S_BR0, 2);
        expect_ev(S_OWN0, 2);
        req  = 2'b01;
        busy = 2'b10;
        repeat (8) @(negedge clk);
        chk("rr_grant_held_busy", 32'(grant), 32'd2);
        busy = 2'b00;
        mark();
        wait_drain("rr_second_grant", 200);
        repeat (48) @(negedge clk);
        expect_ev(S_REL0, 1);
        expect_ev(S_IDLE0, 1);
        req = 2'b00;
        mark();
        wait_drain("rr_release", 100);
        repeat (16) @(negedge clk);

        // Request withdrawn before the CPU grants
        cur_test  = "withdraw";
        cpu_delay = 1000;
        expect_ev(S_BR0, 1);
        req = 2'b01;
        mark();
        wait_drain("withdraw_br", 100);
        repeat (6) @(negedge clk);
        expect_ev(S_IDLE0, 1);
        req = 2'b00;
        mark();
        wait_drain("withdraw_idle", 100);
        repeat (16) @(negedge clk);
        cpu_delay = 3;
        expect_ev(S_BR1, 1);
        expect_ev(S_OWN1, 2);
        req = 2'b10;
        mark();
        wait_drain("withdraw_regrant", 100);
        repeat (6) @(negedge clk);

        // Reset while a requester owns the bus
        cur_test = "reset_own";
        expect_ev(S_IDLE0, -1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_own_next_edge", 32'(cur_snap()), 32'(S_IDLE0));
        reset = 1'b0;
        req   = 2'b00;
        repeat (40) @(negedge clk);
        chk("reset_own_idle", 32'(cur_snap()), 32'(S_IDLE0));
        wait_drain("reset_own", 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
